// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM states, default size, vector-width helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package intc_pkg;

  // Default number of interrupt sources
  localparam int NUM_SRC_DEF = 8;

  // Interrupt handshake phases; only one interrupt is in flight at a time
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Vector width for n sources; at least one bit so the port never collapses
  function automatic int vec_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins, valid flag when any bit is set.
// Latency: purely combinational.
// Backpressure: none; the result follows the input in the same cycle.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int VEC_W   = vec_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [VEC_W-1:0]   idx_o,
  output logic               vld_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = VEC_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intc_core.sv
// Fixed-priority interrupt controller: masks level IRQs, commits one vector to the CPU, returns IACK/IEND pulses.
// Latency: SRC_IRQ sampled in IDLE gives CPU_IRQ the next cycle; ACK/EOI give IACK/IEND pulses the next cycle.
// Backpressure: one interrupt in flight; new requests wait in IDLE until the CPU has acknowledged and ended the current one.
module intc_core
  import intc_pkg::*;
#(
  parameter int                   NUM_SRC    = NUM_SRC_DEF,
  parameter int                   VEC_W      = vec_w(NUM_SRC),
  parameter logic [NUM_SRC-1:0]   MASK_RESET = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [NUM_SRC-1:0] src_irq_i,
  output logic [NUM_SRC-1:0] src_iack_o,
  output logic [NUM_SRC-1:0] src_iend_o,
  output logic               cpu_irq_o,
  output logic [VEC_W-1:0]   cpu_vector_o,
  input  logic               cpu_ack_i,
  input  logic               cpu_eoi_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_data_i,
  output logic               in_service_o,
  output logic [NUM_SRC-1:0] pending_o
);

  localparam logic [NUM_SRC-1:0] ONE_HOT_0 = NUM_SRC'(1);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic                 cpu_irq_q, cpu_irq_d;
  logic                 in_service_q, in_service_d;
  logic [NUM_SRC-1:0]   iack_q, iack_d;
  logic [NUM_SRC-1:0]   iend_q, iend_d;
  logic [NUM_SRC-1:0]   vec_onehot;
  logic [VEC_W-1:0]     arb_idx;
  logic                 arb_vld;

  // Arbitration always sees the mask as it stood before any write in this cycle
  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .req_i (pending_d),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Mask update and masked-request view; a write lands on the next cycle in any state
  always_comb begin
    mask_d    = mask_we_i ? mask_data_i : mask_q;
    pending_d = src_irq_i & ~mask_q;
  end

  // Next-state and registered-output decode for the handshake FSM
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    iack_d     = '0;
    iend_d     = '0;
    vec_onehot = ONE_HOT_0 << vec_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          vec_d   = arb_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        // Vector is committed here; masking or dropping the source cannot retract it
        if (cpu_ack_i) begin
          iack_d  = vec_onehot;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (cpu_eoi_i) begin
          iend_d  = vec_onehot;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cpu_irq_d    = (state_d == REQ);
    in_service_d = (state_d == SERVICE);
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset abandons any in-flight interrupt without pulses
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mask_q       <= MASK_RESET;
      pending_q    <= '0;
      vec_q        <= '0;
      cpu_irq_q    <= 1'b0;
      in_service_q <= 1'b0;
      iack_q       <= '0;
      iend_q       <= '0;
    end else begin
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      vec_q        <= vec_d;
      cpu_irq_q    <= cpu_irq_d;
      in_service_q <= in_service_d;
      iack_q       <= iack_d;
      iend_q       <= iend_d;
    end
  end

  assign src_iack_o   = iack_q;
  assign src_iend_o   = iend_q;
  assign cpu_irq_o    = cpu_irq_q;
  assign cpu_vector_o = vec_q;
  assign in_service_o = in_service_q;
  assign pending_o    = pending_q;

endmodule
